// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the canonical NOP word and the sequential PC step.
package instr_fetch_unit_pkg;

   localparam int unsigned DATA_LEN_C = 32;

   // addi x0,x0,0 -- presented when no instruction is held or on a bus error
   localparam logic [31:0] INSTR_NOP_C = 32'h0000_0013;

   // Byte distance between consecutive instruction words
   localparam int unsigned PC_STEP_C = 4;

   typedef enum logic [1:0] {
      S_RESET = 2'b00,
      S_REQ   = 2'b01,
      S_WAIT  = 2'b10,
      S_VALID = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Keeps the PC, issues one word request at a time
// over req/gnt/rvalid and presents the returned word (with its PC) to decode.
//
// Handshakes:
//   imem request : o_imem_req/o_imem_addr are held stable until i_imem_gnt is
//                  sampled high on a rising edge; i_imem_gnt without a request
//                  is ignored. Exactly one response (i_imem_rvalid) follows
//                  each granted request; i_imem_err is meaningful only with
//                  i_imem_rvalid.
//   decode       : o_instr/o_pc/o_instr_err are stable while o_instr_valid is
//                  high and i_instr_ready is low; the word is consumed on a
//                  rising edge with o_instr_valid and i_instr_ready both high.
//   redirect     : i_redirect wins over everything except reset. A response
//                  already in flight when a redirect arrives is dropped.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned         DATA_LEN  = DATA_LEN_C,
   parameter logic [DATA_LEN-1:0] RESET_PC  = '0,
   parameter logic [DATA_LEN-1:0] NOP_INSTR = DATA_LEN'(INSTR_NOP_C)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   output logic                o_imem_req,
   output logic [DATA_LEN-1:0] o_imem_addr,
   input  logic                i_imem_gnt,
   input  logic                i_imem_rvalid,
   input  logic [DATA_LEN-1:0] i_imem_rdata,
   input  logic                i_imem_err,
   output logic                o_instr_valid,
   input  logic                i_instr_ready,
   output logic [DATA_LEN-1:0] o_instr,
   output logic [DATA_LEN-1:0] o_pc,
   output logic                o_instr_err,
   input  logic                i_redirect,
   input  logic [DATA_LEN-1:0] i_redirect_pc,
   output fetch_state_e        o_state
);

   localparam logic [DATA_LEN-1:0] PC_STEP    = DATA_LEN'(PC_STEP_C);
   localparam logic [DATA_LEN-1:0] ALIGN_MASK = ~(PC_STEP - DATA_LEN'(1));

   fetch_state_e        state_q, state_d;
   logic [DATA_LEN-1:0] pc_q, pc_d;          // next address to request
   logic [DATA_LEN-1:0] pc_req_q, pc_req_d;  // address of the granted request
   logic                discard_q, discard_d;
   logic [DATA_LEN-1:0] instr_q, instr_d;
   logic [DATA_LEN-1:0] out_pc_q, out_pc_d;
   logic                err_q, err_d;
   logic                valid_q, valid_d;
   logic [DATA_LEN-1:0] redirect_pc;

   // Redirect targets are always word aligned
   assign redirect_pc = i_redirect_pc & ALIGN_MASK;

   // Next-state, PC and output-holding-register logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc_req_d  = pc_req_q;
      discard_d = discard_q;
      instr_d   = instr_q;
      out_pc_d  = out_pc_q;
      err_d     = err_q;
      valid_d   = valid_q;

      case (state_q)
         S_RESET: begin
            // redirects are ignored until the first request is up
            state_d = S_REQ;
         end

         S_REQ: begin
            if (i_imem_gnt) begin
               pc_req_d = pc_q;
               state_d  = S_WAIT;
               // the old address was accepted; its response must be dropped
               if (i_redirect) discard_d = 1'b1;
            end
            if (i_redirect) pc_d = redirect_pc;
         end

         S_WAIT: begin
            if (i_imem_rvalid) begin
               if (discard_q || i_redirect) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  instr_d  = i_imem_err ? NOP_INSTR : i_imem_rdata;
                  out_pc_d = pc_req_q;
                  err_d    = i_imem_err;
                  valid_d  = 1'b1;
                  pc_d     = pc_req_q + PC_STEP;
                  state_d  = S_VALID;
               end
            end else if (i_redirect) begin
               discard_d = 1'b1;
            end
            if (i_redirect) pc_d = redirect_pc;
         end

         S_VALID: begin
            if (i_redirect) begin
               // squash the presented word even if decode is ready
               valid_d = 1'b0;
               pc_d    = redirect_pc;
               state_d = S_REQ;
            end else if (i_instr_ready) begin
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // State and output holding registers, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_RESET;
         pc_q      <= RESET_PC;
         pc_req_q  <= RESET_PC;
         discard_q <= 1'b0;
         instr_q   <= NOP_INSTR;
         out_pc_q  <= RESET_PC;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_req_q  <= pc_req_d;
         discard_q <= discard_d;
         instr_q   <= instr_d;
         out_pc_q  <= out_pc_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
      end
   end

   assign o_imem_req    = (state_q == S_REQ);
   assign o_imem_addr   = pc_q;
   assign o_instr_valid = valid_q;
   assign o_instr       = instr_q;
   assign o_pc          = out_pc_q;
   assign o_instr_err   = err_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized
// phase, all checked against a program-order model of the instruction stream.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic        i_clk;
   logic        i_rst_n;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_imem_err;
   logic        o_instr_valid;
   logic        i_instr_ready;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_instr_err;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   fetch_state_e dbg_state;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   instr_fetch_unit dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_imem_err    (i_imem_err),
      .o_instr_valid (o_instr_valid),
      .i_instr_ready (i_instr_ready),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_instr_err   (o_instr_err),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_state       (dbg_state)
   );

   // ---------------- counters ----------------
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // ---------------- memory image and memory knobs ----------------
   logic [31:0] imem [64];
   bit          ierr [64];
   int unsigned gnt_pct   = 100;
   int unsigned max_delay = 0;
   int unsigned stray_pct = 0;
   bit          outstanding = 0;
   logic [31:0] mem_addr    = '0;
   int unsigned mem_delay   = 0;

   // ---------------- reference model: expected program order ----------------
   logic [31:0] exp_pc = 32'h0;       // PC of the next word decode must see
   bit          hold_chk = 0;         // previous cycle was a decode stall
   bit          squash_chk = 0;       // previous cycle carried a redirect
   logic [31:0] hold_pc, hold_instr;
   logic        hold_err;
   bit          chk_interval = 0;
   int unsigned cyc = 0;
   int unsigned last_cyc = 0;
   int unsigned n_deliv = 0;

   // One clock cycle: observe at the falling edge, drive memory/decode/redirect,
   // advance the model, then move to the next falling edge.
   task automatic tick(input bit redir, input logic [31:0] tgt, input bit rdy);
      bit          gnt_v, rv_v, err_v;
      logic [31:0] rd_v;
      logic [5:0]  idx;

      if (squash_chk) check1("after_redirect_valid", o_instr_valid, 1'b0);
      if (hold_chk) begin
         check1("stall_valid", o_instr_valid, 1'b1);
         check1("stall_req", o_imem_req, 1'b0);
         check32("stall_pc", o_pc, hold_pc);
         check32("stall_instr", o_instr, hold_instr);
         check1("stall_err", o_instr_err, hold_err);
      end
      if (o_imem_req) check32("req_addr", o_imem_addr, exp_pc);

      // memory responder: one outstanding request, optional stray pulses
      rv_v  = 1'b0;
      rd_v  = $urandom;
      err_v = 1'($urandom_range(0, 1));
      if (outstanding) begin
         if (mem_delay == 0) begin
            rv_v  = 1'b1;
            rd_v  = imem[mem_addr[7:2]];
            err_v = ierr[mem_addr[7:2]];
            outstanding = 0;
         end else begin
            mem_delay--;
         end
      end else if ($urandom_range(0, 99) < stray_pct) begin
         rv_v = 1'b1;
      end
      if (o_imem_req) gnt_v = ($urandom_range(0, 99) < gnt_pct);
      else            gnt_v = ($urandom_range(0, 99) < stray_pct);
      if (o_imem_req && gnt_v) begin
         outstanding = 1;
         mem_addr    = o_imem_addr;
         mem_delay   = $urandom_range(0, max_delay);
      end

      // in-order delivery: decode sees exp_pc, then exp_pc+4, unless redirected
      if (o_instr_valid && rdy && !redir) begin
         idx = exp_pc[7:2];
         check32("deliver_pc", o_pc, exp_pc);
         check32("deliver_instr", o_instr, ierr[idx] ? NOP : imem[idx]);
         check1("deliver_err", o_instr_err, ierr[idx]);
         if (chk_interval && n_deliv > 0) check32("interval", cyc - last_cyc, 32'd3);
         last_cyc = cyc;
         n_deliv++;
         exp_pc = exp_pc + 32'd4;
      end
      squash_chk = redir;
      hold_chk   = o_instr_valid && !rdy && !redir;
      hold_pc    = o_pc;
      hold_instr = o_instr;
      hold_err   = o_instr_err;
      if (redir) exp_pc = tgt & 32'hFFFF_FFFC;

      i_imem_gnt    = gnt_v;
      i_imem_rvalid = rv_v;
      i_imem_rdata  = rd_v;
      i_imem_err    = err_v;
      i_instr_ready = rdy;
      i_redirect    = redir;
      i_redirect_pc = tgt;
      @(posedge i_clk);
      @(negedge i_clk);
      cyc++;
   endtask

   task automatic run_until_valid(input bit rdy);
      for (int k = 0; k < 30; k++) begin
         if (o_instr_valid) break;
         tick(1'b0, 32'h0, rdy);
      end
      check1("wait_valid", o_instr_valid, 1'b1);
   endtask

   task automatic run_until_req();
      for (int k = 0; k < 30; k++) begin
         if (o_imem_req) break;
         tick(1'b0, 32'h0, 1'b1);
      end
      check1("wait_req", o_imem_req, 1'b1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int unsigned rand_start;
      for (int i = 0; i < 64; i++) begin
         imem[i] = $urandom;
         ierr[i] = ($urandom_range(0, 7) == 0);
      end
      imem[1]  = 32'h0050_0093;
      ierr[0]  = 0;  ierr[1] = 0;  ierr[2] = 0;  ierr[3] = 0;
      ierr[8]  = 1;  ierr[9] = 0;  ierr[63] = 0;

      i_rst_n = 1'b0;  i_imem_gnt = 1'b0;  i_imem_rvalid = 1'b0;
      i_imem_rdata = '0;  i_imem_err = 1'b0;  i_instr_ready = 1'b0;
      i_redirect = 1'b0;  i_redirect_pc = '0;
      repeat (3) @(negedge i_clk);

      // reset values
      check1("rst_req", o_imem_req, 1'b0);
      check1("rst_valid", o_instr_valid, 1'b0);
      check32("rst_instr", o_instr, NOP);
      check32("rst_pc", o_pc, 32'h0);
      check1("rst_err", o_instr_err, 1'b0);
      check32("rst_state", 32'(dbg_state), 32'(S_RESET));

      // release; a redirect in the very first cycle must be ignored
      i_rst_n = 1'b1;  i_redirect = 1'b1;  i_redirect_pc = 32'h500;
      @(posedge i_clk);
      @(negedge i_clk);
      i_redirect = 1'b0;
      check32("first_state", 32'(dbg_state), 32'(S_REQ));
      check1("first_req", o_imem_req, 1'b1);
      check32("first_addr", o_imem_addr, 32'h0);

      // zero-wait memory, decode always ready: 0x0,0x4,0x8 every 3rd cycle
      chk_interval = 1;
      for (int k = 0; k < 20; k++) begin
         if (n_deliv >= 3) break;
         tick(1'b0, 32'h0, 1'b1);
      end
      check32("zero_wait_count", n_deliv, 32'd3);
      chk_interval = 0;

      // decode stall on 0x00500093 @0x4, then continue at 0x8
      tick(1'b1, 32'h4, 1'b1);
      run_until_valid(1'b0);
      check32("stall_first_pc", o_pc, 32'h4);
      check32("stall_first_instr", o_instr, 32'h0050_0093);
      repeat (5) tick(1'b0, 32'h0, 1'b0);
      check32("stall_end_instr", o_instr, 32'h0050_0093);
      tick(1'b0, 32'h0, 1'b1);
      run_until_req();
      check32("after_stall_addr", o_imem_addr, 32'h8);

      // redirect to 0x100 while waiting for 0x8
      tick(1'b0, 32'h0, 1'b1);
      check32("wait_state", 32'(dbg_state), 32'(S_WAIT));
      tick(1'b1, 32'h100, 1'b1);
      run_until_req();
      check32("redir_wait_addr", o_imem_addr, 32'h100);
      run_until_valid(1'b0);
      check32("redir_wait_pc", o_pc, 32'h100);
      tick(1'b0, 32'h0, 1'b1);

      // redirect on the grant cycle of 0xC, target 0x203 -> 0x200
      tick(1'b1, 32'hC, 1'b1);
      run_until_req();
      check32("pre_gnt_addr", o_imem_addr, 32'hC);
      tick(1'b1, 32'h203, 1'b1);
      tick(1'b0, 32'h0, 1'b1);
      check1("gnt_redir_no_valid", o_instr_valid, 1'b0);
      run_until_req();
      check32("gnt_redir_addr", o_imem_addr, 32'h200);
      // redirect while presenting: squashed despite ready
      run_until_valid(1'b0);
      check32("squash_pc", o_pc, 32'h200);
      tick(1'b1, 32'h300, 1'b1);
      check1("squash_valid", o_instr_valid, 1'b0);

      // bus error at 0x20
      tick(1'b1, 32'h20, 1'b1);
      run_until_valid(1'b0);
      check32("err_instr", o_instr, NOP);
      check1("err_flag", o_instr_err, 1'b1);
      check32("err_pc", o_pc, 32'h20);
      tick(1'b0, 32'h0, 1'b1);
      run_until_req();
      check32("after_err_addr", o_imem_addr, 32'h24);

      // PC wrap at the top of the address space
      tick(1'b1, 32'hFFFF_FFFC, 1'b1);
      run_until_valid(1'b0);
      check32("wrap_pc", o_pc, 32'hFFFF_FFFC);
      tick(1'b0, 32'h0, 1'b1);
      run_until_req();
      check32("wrap_addr", o_imem_addr, 32'h0);

      // asynchronous reset while waiting for a response
      tick(1'b0, 32'h0, 1'b1);
      check32("pre_rst_state", 32'(dbg_state), 32'(S_WAIT));
      #2 i_rst_n = 1'b0;
      #1;
      check1("arst_req", o_imem_req, 1'b0);
      check1("arst_valid", o_instr_valid, 1'b0);
      check32("arst_instr", o_instr, NOP);
      check32("arst_pc", o_pc, 32'h0);
      check1("arst_err", o_instr_err, 1'b0);
      check32("arst_state", 32'(dbg_state), 32'(S_RESET));
      @(negedge i_clk);
      i_rst_n    = 1'b1;
      exp_pc     = 32'h0;
      hold_chk   = 0;
      squash_chk = 0;
      // the aborted request's response arrives now and must be ignored
      tick(1'b0, 32'h0, 1'b1);
      check1("late_rvalid_valid", o_instr_valid, 1'b0);
      run_until_valid(1'b1);
      check32("post_rst_pc", o_pc, 32'h0);

      // randomized phase
      gnt_pct    = 60;
      max_delay  = 3;
      stray_pct  = 5;
      rand_start = n_deliv;
      for (int k = 0; k < 1500; k++) begin
         tick(($urandom_range(0, 99) < 4), $urandom, ($urandom_range(0, 99) < 70));
      end
      n_total++;
      assert (n_deliv - rand_start >= 20) n_pass++;
      else $error("FAIL random_progress: observed %0d expected >= 20", n_deliv - rand_start);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
